// File: rtl/pc_fetch.sv
// pc_fetch: architectural PC register and instruction-fetch sequencer for the
// multicycle MIPS datapath. It fetches the word at pc over a req/ack handshake,
// holds it for decode, and loads pc from the next-PC unit when decode accepts.
//
// State table
//   state  | meaning
//   S_REQ  | fetch outstanding at pc; waiting for imem_ack
//   S_HOLD | instruction held in ir for decode; waiting for ir_accept
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   npc        [31:2]   : next PC from the next-PC unit, sampled on accept
//   pc         [31:2]   : current PC, to the next-PC unit
//   imem_req / imem_addr: fetch request and word address (== pc)
//   imem_ack / imem_rdata / imem_err : memory response, data, fault
//   ir / ir_valid / ir_fault : held instruction, valid flag, fault flag
//   ir_accept           : decode/execute finished with ir; npc is final
//   instret    [31:0]   : count of accepted instructions
module pc_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] npc,
  output logic [31:2] pc,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        ir_fault,
  input  logic        ir_accept,
  output logic [31:0] instret
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:2] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_fault_q, ir_fault_d;
  logic [31:0] instret_q, instret_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      ir_fault_q <= 1'b0;
      instret_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_fault_q <= ir_fault_d;
      instret_q  <= instret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_fault_d = ir_fault_q;
    instret_d  = instret_q;
    case (state_q)
      S_REQ: begin
        // ir_accept is meaningless until an instruction is held.
        if (imem_ack) begin
          // A faulted fetch delivers a nop; the trap is taken from ir_fault.
          ir_d       = imem_err ? 32'h0 : imem_rdata;
          ir_fault_d = imem_err;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        // A stray ack here is discarded.
        if (ir_accept) begin
          pc_d      = npc;
          instret_d = instret_q + 32'd1;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // The request is masked while reset is held so nothing is issued until the
  // first cycle after release.
  assign imem_req  = (state_q == S_REQ) && !rst;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign ir_valid  = (state_q == S_HOLD);
  assign ir_fault  = ir_fault_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:2] npc;
  logic [31:2] pc;
  logic        imem_req;
  logic [31:2] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_fault;
  logic        ir_accept;
  logic [31:0] instret;

  int checks = 0;
  int failures = 0;

  // Reference model: what the fetch unit is architecturally holding.
  logic [29:0] m_pc;
  logic [31:0] m_ir;
  logic        m_fault;
  logic [31:0] m_instret;
  bit          m_have_instr;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(30'h0000_0C00)) dut (
    .clk(clk), .rst(rst), .npc(npc), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err), .ir(ir),
    .ir_valid(ir_valid), .ir_fault(ir_fault), .ir_accept(ir_accept),
    .instret(instret)
  );

  task automatic model_reset();
    m_pc = 30'h0C00;
    m_ir = 32'h0;
    m_fault = 1'b0;
    m_instret = 32'h0;
    m_have_instr = 0;
  endtask

  // One clock: the model consumes the inputs as they stand at the rising edge,
  // then outputs are observed at the falling edge.
  task automatic step();
    logic [29:0] n_pc;
    logic [31:0] n_ir, n_inst;
    logic        n_fault;
    bit          n_have;
    n_pc = m_pc; n_ir = m_ir; n_fault = m_fault; n_inst = m_instret; n_have = m_have_instr;
    if (!rst) begin
      if (!m_have_instr && imem_ack) begin
        n_ir = imem_err ? 32'h0 : imem_rdata;
        n_fault = imem_err;
        n_have = 1;
      end else if (m_have_instr && ir_accept) begin
        n_pc = npc;
        n_inst = m_instret + 1;
        n_have = 0;
      end
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_pc = n_pc; m_ir = n_ir; m_fault = n_fault; m_instret = n_inst; m_have_instr = n_have;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_ack = 1'b0;
    imem_err = 1'b0;
    ir_accept = 1'b0;
  endtask

  task automatic fetch_and_accept(input logic [29:0] next);
    imem_ack = 1'b1; imem_rdata = $urandom; imem_err = 1'b0;
    step();
    imem_ack = 1'b0; ir_accept = 1'b1; npc = next;
    step();
    ir_accept = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    npc = 30'h0; imem_rdata = 32'h0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b0 || pc !== 30'h0C00 || ir_valid !== 1'b0 ||
          instret !== 32'h0 || ir !== 32'h0 || ir_fault !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: req=%b pc=%h ir_valid=%b instret=%h ir=%h fault=%b",
                 imem_req, pc, ir_valid, instret, ir, ir_fault);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 30'h0C00 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: req=%b addr=%h ir_valid=%b (want 1 0c00 0)",
               imem_req, imem_addr, ir_valid);
    end
  endtask

  task automatic test_zero_wait();
    imem_ack = 1'b1; imem_rdata = 32'h2408_0005; imem_err = 1'b0;
    step();
    imem_ack = 1'b0;
    checks++;
    if (ir !== 32'h2408_0005 || ir_valid !== 1'b1 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL zero_wait_ir: ir=%h valid=%b req=%b want 24080005 1 0", ir, ir_valid, imem_req);
    end
    ir_accept = 1'b1; npc = 30'h0C01;
    step();
    ir_accept = 1'b0;
    checks++;
    if (pc !== 30'h0C01 || imem_req !== 1'b1 || instret !== 32'd1 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_wait_accept: pc=%h req=%b instret=%0d valid=%b want 0c01 1 1 0",
               pc, imem_req, instret, ir_valid);
    end
  endtask

  task automatic test_wait_states();
    logic [29:0] addr0;
    addr0 = m_pc;
    for (int i = 0; i < 3; i++) begin
      ir_accept = 1'b1; npc = $urandom;
      step();
      checks++;
      if (imem_addr !== addr0 || imem_req !== 1'b1 || ir_valid !== 1'b0 ||
          instret !== m_instret || pc !== addr0) begin
        failures++;
        $display("FAIL wait_state: addr=%h req=%b valid=%b instret=%0d want addr=%h",
                 imem_addr, imem_req, ir_valid, instret, addr0);
      end
    end
    ir_accept = 1'b0;
    imem_ack = 1'b1; imem_rdata = $urandom;
    step();
    imem_ack = 1'b0;
    checks++;
    if (ir !== m_ir || ir_valid !== 1'b1 || ir_fault !== 1'b0) begin
      failures++;
      $display("FAIL wait_ack: ir=%h valid=%b fault=%b want ir=%h", ir, ir_valid, ir_fault, m_ir);
    end
  endtask

  task automatic test_decode_stall();
    logic [29:0] pc0;
    logic [31:0] ir0;
    pc0 = pc; ir0 = m_ir;
    for (int i = 0; i < 5; i++) begin
      npc = $urandom; imem_ack = 1'($urandom); imem_rdata = $urandom; imem_err = 1'($urandom);
      step();
      checks++;
      if (pc !== m_pc || ir !== ir0 || imem_req !== 1'b0 || ir_valid !== 1'b1 || ir_fault !== 1'b0) begin
        failures++;
        $display("FAIL decode_stall: pc=%h ir=%h req=%b valid=%b fault=%b want pc=%h ir=%h",
                 pc, ir, imem_req, ir_valid, ir_fault, pc0, ir0);
      end
    end
    idle_inputs();
    ir_accept = 1'b1; npc = 30'h1000;
    step();
    ir_accept = 1'b0;
    checks++;
    if (pc !== 30'h1000 || imem_req !== 1'b1 || instret !== m_instret) begin
      failures++;
      $display("FAIL stall_accept: pc=%h req=%b instret=%0d want 1000 1 %0d", pc, imem_req, instret, m_instret);
    end
  endtask

  task automatic test_fault();
    imem_ack = 1'b1; imem_err = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    checks++;
    if (ir !== 32'h0 || ir_fault !== 1'b1 || ir_valid !== 1'b1) begin
      failures++;
      $display("FAIL fault_fetch: ir=%h fault=%b valid=%b want 0 1 1", ir, ir_fault, ir_valid);
    end
    ir_accept = 1'b1; npc = 30'h1001;
    step();
    ir_accept = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
    step();
    imem_ack = 1'b0;
    checks++;
    if (ir !== 32'h8C22_0004 || ir_fault !== 1'b0 || pc !== 30'h1001) begin
      failures++;
      $display("FAIL fault_clear: ir=%h fault=%b pc=%h want 8c220004 0 1001", ir, ir_fault, pc);
    end
    ir_accept = 1'b1; npc = 30'h1002;
    step();
    ir_accept = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Bring the block to pc=0x1000 with 7 retired instructions, fetch pending.
    while (m_instret < 32'd6) fetch_and_accept(30'h0800 + 30'(m_instret));
    fetch_and_accept(30'h1000);
    step();
    checks++;
    if (pc !== 30'h1000 || instret !== 32'd7 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup: pc=%h instret=%0d req=%b want 1000 7 1", pc, instret, imem_req);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (pc !== 30'h0C00 || instret !== 32'h0 || imem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 32'h0) begin
      failures++;
      $display("FAIL mid_async: pc=%h instret=%0d req=%b valid=%b ir=%h want 0c00 0 0 0 0",
               pc, instret, imem_req, ir_valid, ir);
    end
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    imem_ack = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 30'h0C00 || ir_valid !== 1'b0 || ir !== 32'h0) begin
      failures++;
      $display("FAIL mid_release: req=%b addr=%h valid=%b ir=%h want 1 0c00 0 0",
               imem_req, imem_addr, ir_valid, ir);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      imem_ack = ($urandom_range(0, 2) == 0);
      imem_err = ($urandom_range(0, 3) == 0);
      imem_rdata = $urandom;
      ir_accept = ($urandom_range(0, 2) == 0);
      npc = (i % 50 == 7) ? 30'h3FFF_FFFF : 30'($urandom);
      step();
      checks++;
      if (pc !== m_pc || imem_addr !== m_pc || ir !== m_ir || ir_fault !== m_fault ||
          instret !== m_instret || ir_valid !== 1'(m_have_instr) || imem_req !== 1'(!m_have_instr)) begin
        failures++;
        bad++;
        if (bad < 10)
          $display("FAIL random[%0d]: pc=%h/%h ir=%h/%h fault=%b/%b instret=%0d/%0d valid=%b/%b req=%b",
                   i, pc, m_pc, ir, m_ir, ir_fault, m_fault, instret, m_instret,
                   ir_valid, m_have_instr, imem_req);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_decode_stall();
    test_fault();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
